// File: rtl/led_scanner_pkg.sv
// Shared types for the LED pattern engine.
// Mode encoding and scan direction constants.
package led_scanner_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE   = 2'd0,
        MODE_ROT_UP   = 2'd1,
        MODE_ROT_DOWN = 2'd2,
        MODE_BREATHE  = 2'd3
    } mode_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_scanner_if.sv
// Control/status bundle between a host block and the LED scanner.
// The host drives mode/pause/step; the scanner returns pins and tick.
interface led_scanner_if #(
    parameter int N_LEDS = 4
);
    import led_scanner_pkg::*;

    mode_t             mode;
    logic              pause;
    logic              step;
    logic [N_LEDS-1:0] led;
    logic              tick;

    modport master (
        output mode, pause, step,
        input  led, tick
    );

    modport slave (
        input  mode, pause, step,
        output led, tick
    );

endinterface

// File: rtl/led_prescaler.sv
// Free-running power-of-two prescaler with a registered wrap pulse.
// tick is high for the one cycle after div rolls over to zero.
module led_prescaler #(
    parameter int DIV_WIDTH = 21
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 tick_q, tick_d;

    always_comb begin
        div_d  = div_q + DIV_WIDTH'(1);
        tick_d = &div_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_scanner.sv
// LED pattern engine: bounce, rotate up/down and PWM breathe,
// with pause/single-step control and a prescaler tick output.
module led_scanner
    import led_scanner_pkg::*;
#(
    parameter int N_LEDS     = 4,
    parameter int DIV_WIDTH  = 21,
    parameter int PWM_BITS   = 6,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    led_scanner_if.slave  bus
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

    logic                tick_w;
    logic                adv;
    logic                pwm_on;
    logic [N_LEDS-1:0]   pattern;
    logic [N_LEDS-1:0]   pos_q, pos_d;
    logic                dir_q, dir_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic                lvl_dir_q, lvl_dir_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [N_LEDS-1:0]   led_q, led_d;

    led_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_w)
    );

    assign adv = (tick_w & ~bus.pause) | bus.step;

    always_comb begin
        pos_d     = pos_q;
        dir_d     = dir_q;
        level_d   = level_q;
        lvl_dir_d = lvl_dir_q;
        pwm_d     = pwm_q + PWM_BITS'(1);
        if (adv) begin
            if (bus.mode == MODE_BREATHE) begin
                // Flip on reaching an end so the end value is not repeated.
                if (lvl_dir_q == DIR_UP) begin
                    level_d = level_q + PWM_BITS'(1);
                    if (level_q == LVL_MAX - PWM_BITS'(1)) lvl_dir_d = DIR_DOWN;
                end else begin
                    level_d = level_q - PWM_BITS'(1);
                    if (level_q == PWM_BITS'(1)) lvl_dir_d = DIR_UP;
                end
            end else if (pos_q == '0) begin
                pos_d = N_LEDS'(1);
                dir_d = DIR_UP;
            end else begin
                unique case (bus.mode)
                    MODE_BOUNCE: begin
                        if (dir_q == DIR_UP) begin
                            if (pos_q[N_LEDS-1]) begin
                                pos_d = pos_q >> 1;
                                dir_d = DIR_DOWN;
                            end else begin
                                pos_d = pos_q << 1;
                            end
                        end else begin
                            if (pos_q[0]) begin
                                pos_d = pos_q << 1;
                                dir_d = DIR_UP;
                            end else begin
                                pos_d = pos_q >> 1;
                            end
                        end
                    end
                    MODE_ROT_UP: begin
                        pos_d = {pos_q[N_LEDS-2:0], pos_q[N_LEDS-1]};
                        dir_d = DIR_UP;
                    end
                    MODE_ROT_DOWN: begin
                        pos_d = {pos_q[0], pos_q[N_LEDS-1:1]};
                        dir_d = DIR_DOWN;
                    end
                    MODE_BREATHE: begin
                    end
                endcase
            end
        end
        pwm_on  = pwm_q < level_q;
        pattern = (bus.mode == MODE_BREATHE) ? {N_LEDS{pwm_on}} : pos_q;
        led_d   = pattern ^ {N_LEDS{ACTIVE_LOW}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q     <= '0;
            dir_q     <= DIR_UP;
            level_q   <= '0;
            lvl_dir_q <= DIR_UP;
            pwm_q     <= '0;
            led_q     <= {N_LEDS{ACTIVE_LOW}};
        end else begin
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            level_q   <= level_d;
            lvl_dir_q <= lvl_dir_d;
            pwm_q     <= pwm_d;
            led_q     <= led_d;
        end
    end

    assign bus.led  = led_q;
    assign bus.tick = tick_w;

endmodule

// File: tb/tb_led_scanner.sv
// Directed bench: 4-LED active-low scanner with a fast prescaler,
// plus an 8-LED active-high instance for a full bounce cycle.
module tb_led_scanner;
    import led_scanner_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    led_scanner_if #(.N_LEDS(4)) a ();
    led_scanner_if #(.N_LEDS(8)) b ();

    led_scanner #(
        .N_LEDS     (4),
        .DIV_WIDTH  (2),
        .PWM_BITS   (2),
        .ACTIVE_LOW (1'b1)
    ) u_a (
        .clk (clk),
        .rst (rst),
        .bus (a)
    );

    led_scanner #(
        .N_LEDS     (8),
        .DIV_WIDTH  (2),
        .PWM_BITS   (2),
        .ACTIVE_LOW (1'b0)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Returns edges waited until tick was visible, bounded.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (a.tick !== 1'b1 && n < 20);
        chk("tick_seen", {31'd0, a.tick}, 32'd1);
    endtask

    task automatic tick_adv(input string tag, input logic [3:0] exp);
        int n;
        wait_tick(n);
        cyc();
        cyc();
        chk(tag, {28'd0, a.led}, {28'd0, exp});
    endtask

    task automatic step_a();
        a.step = 1'b1;
        cyc();
        a.step = 1'b0;
    endtask

    task automatic step_b();
        b.step = 1'b1;
        cyc();
        b.step = 1'b0;
    endtask

    initial begin
        logic [3:0] bounce_exp [7];
        int lvl_exp [7];
        int n;
        int lit;
        logic all_eq;
        logic [7:0] eb;

        bounce_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1011,
                       4'b1101, 4'b1110, 4'b1101};
        lvl_exp = '{1, 2, 3, 2, 1, 0, 1};
        n_tests = 0;
        n_fail  = 0;
        a.mode  = MODE_BOUNCE;
        a.pause = 1'b0;
        a.step  = 1'b0;
        b.mode  = MODE_BOUNCE;
        b.pause = 1'b1;
        b.step  = 1'b0;

        rst = 1'b1;
        cyc();
        cyc();
        chk("rst_led", {28'd0, a.led}, 32'hf);
        chk("rst_tick", {31'd0, a.tick}, 32'd0);
        chk("rst_led_b", {24'd0, b.led}, 32'h0);
        rst = 1'b0;

        wait_tick(n);
        chk("first_tick_lat", n, 4);
        chk("pre_tick_led", {28'd0, a.led}, 32'hf);
        cyc();
        chk("adv_led_lag", {28'd0, a.led}, 32'hf);
        cyc();
        chk("first_pos", {28'd0, a.led}, 32'he);
        for (int i = 0; i < 7; i++)
            tick_adv($sformatf("bounce%0d", i), bounce_exp[i]);

        do_reset();
        a.mode = MODE_ROT_UP;
        tick_adv("rot_up0", 4'b1110);
        tick_adv("rot_up1", 4'b1101);
        tick_adv("rot_up2", 4'b1011);
        tick_adv("rot_up3", 4'b0111);
        tick_adv("rot_up4", 4'b1110);
        tick_adv("rot_up5", 4'b1101);
        tick_adv("rot_up6", 4'b1011);
        tick_adv("rot_up7", 4'b0111);
        a.mode = MODE_ROT_DOWN;
        tick_adv("rot_down", 4'b1011);
        a.mode = MODE_BOUNCE;
        tick_adv("dir_kept", 4'b1101);

        a.pause = 1'b1;
        wait_tick(n);
        wait_tick(n);
        cyc();
        cyc();
        chk("pause_frozen", {28'd0, a.led}, 32'hd);
        step_a();
        cyc();
        chk("step1", {28'd0, a.led}, 32'he);
        step_a();
        cyc();
        chk("step2", {28'd0, a.led}, 32'hd);
        a.pause = 1'b0;
        wait_tick(n);
        step_a();
        cyc();
        chk("step_and_tick", {28'd0, a.led}, 32'hb);

        do_reset();
        a.mode  = MODE_BREATHE;
        a.pause = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step_a();
            lit = 0;
            all_eq = 1'b1;
            for (int k = 0; k < 4; k++) begin
                cyc();
                if (a.led == 4'b0000) lit++;
                else if (a.led != 4'b1111) all_eq = 1'b0;
            end
            chk($sformatf("breathe_duty%0d", i), lit, lvl_exp[i]);
            chk($sformatf("breathe_uniform%0d", i), {31'd0, all_eq}, 32'd1);
        end

        do_reset();
        a.mode  = MODE_BOUNCE;
        a.pause = 1'b1;
        for (int i = 0; i < 5; i++) step_a();
        cyc();
        chk("mid_bounce", {28'd0, a.led}, 32'hb);
        rst = 1'b1;
        cyc();
        chk("mid_rst_led", {28'd0, a.led}, 32'hf);
        chk("mid_rst_tick", {31'd0, a.tick}, 32'd0);
        rst = 1'b0;
        a.pause = 1'b0;
        wait_tick(n);
        chk("post_rst_lat", n, 4);
        chk("post_rst_off", {28'd0, a.led}, 32'hf);
        cyc();
        cyc();
        chk("post_rst_first", {28'd0, a.led}, 32'he);

        step_b();
        cyc();
        chk("b_first", {24'd0, b.led}, 32'h01);
        for (int i = 0; i < 14; i++) begin
            eb = (i < 7) ? (8'h02 << i) : (8'h80 >> (i - 6));
            step_b();
            cyc();
            chk($sformatf("b_bounce%0d", i), {24'd0, b.led}, {24'd0, eb});
            chk($sformatf("b_onehot%0d", i), {31'd0, $onehot(b.led)}, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
